// File: rtl/motor_speed_pwm.sv
// Closed-loop speed stage: step-clamped integral command slewing towards target_rpm,
// driving a dead-period-protected PWM + direction pair and an at-speed flag.
`timescale 1ns/1ps
module motor_speed_pwm #(
  parameter int UPDATE_CYCLES = 10000001,
  parameter int PRESCALE      = 4,
  parameter int STEP_MAX      = 16,
  parameter int TOL           = 2
) (
  input  logic       cclk,
  input  logic       rstb,
  input  logic       enable,
  input  logic [7:0] rpm,
  input  logic [7:0] target_rpm,
  output logic       pwm,
  output logic       dir,
  output logic [7:0] duty,
  output logic       at_speed
);

  localparam int UW = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic signed [8:0] STEP_P = 9'(STEP_MAX);
  localparam logic signed [8:0] STEP_N = -STEP_P;
  localparam logic [8:0]        TOL_U  = 9'(TOL);

  typedef enum logic [1:0] {IDLE, SAMPLE, COMPUTE, APPLY} state_t;
  state_t state, state_next;

  logic [UW-1:0]     upd_cnt;
  logic              upd_tick;
  logic [PW-1:0]     pre_cnt;
  logic              pre_wrap;
  logic [7:0]        pwm_cnt;
  logic              period_start;
  logic signed [8:0] err;
  logic signed [8:0] cmd;
  logic signed [8:0] nxt;
  logic signed [8:0] step;
  logic signed [8:0] nxt_sat;
  logic signed [9:0] sum;
  logic [8:0]        err_mag;
  logic [7:0]        cmd_mag;
  logic              dead;

  assign upd_tick     = (upd_cnt == UW'(UPDATE_CYCLES - 1));
  assign pre_wrap     = (pre_cnt == PW'(PRESCALE - 1));
  assign period_start = pre_wrap && (pwm_cnt == 8'hFF);

  // Free-running timers; only reset stops them, enable does not.
  always_ff @(posedge cclk) begin
    if (!rstb) begin
      upd_cnt <= '0;
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      upd_cnt <= upd_tick ? '0 : upd_cnt + 1'b1;
      pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
      if (pre_wrap) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  always_comb begin
    step = err;
    if (err > STEP_P)      step = STEP_P;
    else if (err < STEP_N) step = STEP_N;
    sum     = {cmd[8], cmd} + {step[8], step};
    nxt_sat = sum[8:0];
    if (sum > 10'sd255)       nxt_sat = 9'sd255;
    else if (sum < -10'sd255) nxt_sat = -9'sd255;
    err_mag = err[8] ? 9'(-err) : err;
    cmd_mag = cmd[8] ? 8'(-cmd) : cmd[7:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (upd_tick) state_next = SAMPLE;
      SAMPLE:  state_next = COMPUTE;
      COMPUTE: state_next = APPLY;
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (!enable) state_next = IDLE;
  end

  // Disable aborts any update in flight, so a tick coinciding with enable=0 is lost.
  always_ff @(posedge cclk) begin
    if (!rstb) begin
      state    <= IDLE;
      err      <= '0;
      nxt      <= '0;
      cmd      <= '0;
      at_speed <= 1'b0;
    end else begin
      state <= state_next;
      if (enable && state == SAMPLE) err <= {target_rpm[7], target_rpm} - {rpm[7], rpm};
      if (enable && state == COMPUTE) begin
        nxt      <= nxt_sat;
        at_speed <= (err_mag <= TOL_U);
      end
      if (!enable)             cmd <= '0;
      else if (state == APPLY) cmd <= nxt;
    end
  end

  // Duty and direction only move at period start; a sign change blanks one whole period.
  always_ff @(posedge cclk) begin
    if (!rstb) begin
      duty <= '0;
      dir  <= 1'b0;
      dead <= 1'b0;
      pwm  <= 1'b0;
    end else begin
      pwm <= enable & ~dead & (pwm_cnt < duty);
      if (period_start) begin
        duty <= cmd_mag;
        if (cmd[8] != dir) begin
          dead <= 1'b1;
          dir  <= cmd[8];
        end else begin
          dead <= 1'b0;
        end
      end
    end
  end

endmodule
